// File: rtl/hilo_unit_if.sv
// hilo_unit_if: request, engine handshake, MTHI/MTLO and HI/LO result bundle for hilo_unit
// master: control unit plus multiplier/divider side; slave: hilo_unit
interface hilo_unit_if #(parameter int WIDTH = 32);
  logic op_start, op_sel, mult_start, mult_end, div_start, div_end, div_zero;
  logic hi_write, lo_write, busy, done, div0_exc, timeout_err;
  logic [WIDTH-1:0] mult_high, mult_low, div_high, div_low, wdata, hi, lo;
  modport master(
    output op_start, op_sel, mult_end, mult_high, mult_low, div_end, div_zero, div_high, div_low,
    output hi_write, lo_write, wdata,
    input mult_start, div_start, busy, done, div0_exc, timeout_err, hi, lo
  );
  modport slave(
    input op_start, op_sel, mult_end, mult_high, mult_low, div_end, div_zero, div_high, div_low,
    input hi_write, lo_write, wdata,
    output mult_start, div_start, busy, done, div0_exc, timeout_err, hi, lo
  );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO registers plus MULT/DIV launch/wait sequencer with timeout
// clk, reset (sync, active-high); bus: hilo_unit_if slave (op request, engine start/end/results, MTHI/MTLO, busy, result pulses, hi/lo)
module hilo_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input logic         clk,
  input logic         reset,
  hilo_unit_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIN} state_t;
  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, div0_q, div0_d, to_q, to_d;
  logic             end_sel;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
      to_q    <= to_d;
    end
  end
  // only the launched engine's end flag matters; the other one may hold a stale level
  assign end_sel = op_q ? bus.div_end : bus.mult_end;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        hi_d = bus.hi_write ? bus.wdata : hi_q;
        lo_d = bus.lo_write ? bus.wdata : lo_q;
        if (bus.op_start) begin
          op_d    = bus.op_sel;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (end_sel) begin
          state_d = FIN;
          if (op_q && bus.div_zero) div0_d = 1'b1;
          else begin
            done_d = 1'b1;
            hi_d   = op_q ? bus.div_high : bus.mult_high;
            lo_d   = op_q ? bus.div_low : bus.mult_low;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = FIN;
          to_d    = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      FIN: state_d = IDLE;
    endcase
  end
  assign bus.mult_start  = (state_q == LAUNCH) && !op_q;
  assign bus.div_start   = (state_q == LAUNCH) && op_q;
  assign bus.busy        = (state_q == LAUNCH) || (state_q == WAIT);
  assign bus.done        = done_q;
  assign bus.div0_exc    = div0_q;
  assign bus.timeout_err = to_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed vector bench for hilo_unit
module tb_hilo_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  hilo_unit_if #(.WIDTH(32)) bus();
  hilo_unit #(.WIDTH(32), .TIMEOUT(64)) dut(.clk(clk), .reset(reset), .bus(bus));
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic        do_wr;
    logic [31:0] wr_hi, wr_lo;
    logic        sel;
    int          lat;
    logic        zero;
    logic [31:0] rh, rl;
    logic [2:0]  exp_flags;
    logic [31:0] eh, el;
  } vec_t;
  vec_t vecs[7];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [2:0] flags();
    return {bus.done, bus.div0_exc, bus.timeout_err};
  endfunction
  task automatic run_op(input vec_t v);
    int w_end;
    w_end = (v.lat == 0) ? 64 : v.lat;
    if (v.do_wr) begin
      bus.hi_write = 1'b1;
      bus.wdata = v.wr_hi;
      tick();
      bus.hi_write = 1'b0;
      bus.lo_write = 1'b1;
      bus.wdata = v.wr_lo;
      tick();
      bus.lo_write = 1'b0;
      check("mthi", bus.hi, v.wr_hi);
      check("mtlo", bus.lo, v.wr_lo);
    end
    check("start_idle", {bus.mult_start, bus.div_start}, 2'b00);
    bus.op_sel = v.sel;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
    check("mult_start", bus.mult_start, !v.sel);
    check("div_start", bus.div_start, v.sel);
    check("busy_launch", bus.busy, 1'b1);
    for (int w = 1; w <= w_end; w++) begin
      tick();
      if (w == 1) check("start_once", {bus.mult_start, bus.div_start}, 2'b00);
      check("busy_wait", bus.busy, 1'b1);
      check("flags_wait", flags(), 3'b000);
      if (v.sel) begin
        bus.div_end = (v.lat != 0) && (w >= v.lat);
        bus.div_zero = v.zero;
        bus.div_high = v.rh;
        bus.div_low = v.rl;
      end else begin
        bus.mult_end = (v.lat != 0) && (w >= v.lat);
        bus.mult_high = v.rh;
        bus.mult_low = v.rl;
      end
    end
    tick();
    check("flags_fin", flags(), v.exp_flags);
    check("busy_fin", bus.busy, 1'b0);
    check("hi_fin", bus.hi, v.eh);
    check("lo_fin", bus.lo, v.el);
    tick();
    check("flags_idle", flags(), 3'b000);
    check("busy_idle", bus.busy, 1'b0);
  endtask
  initial begin
    reset = 1'b1;
    {bus.op_start, bus.op_sel, bus.mult_end, bus.div_end, bus.div_zero, bus.hi_write, bus.lo_write} = '0;
    {bus.mult_high, bus.mult_low, bus.div_high, bus.div_low, bus.wdata} = '0;
    vecs[0] = '{1'b0, 32'h0, 32'h0, 1'b0, 31, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, 3'b100, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{1'b0, 32'h0, 32'h0, 1'b0, 3, 1'b0, 32'h12345678, 32'h9ABCDEF0, 3'b100, 32'h12345678, 32'h9ABCDEF0};
    vecs[2] = '{1'b0, 32'h0, 32'h0, 1'b1, 5, 1'b0, 32'h00000001, 32'h00000002, 3'b100, 32'h00000001, 32'h00000002};
    vecs[3] = '{1'b1, 32'h11, 32'h22, 1'b1, 4, 1'b1, 32'h0000DEAD, 32'h0000BEEF, 3'b010, 32'h11, 32'h22};
    vecs[4] = '{1'b0, 32'h0, 32'h0, 1'b0, 0, 1'b0, 32'h0000AAAA, 32'h0000BBBB, 3'b001, 32'h11, 32'h22};
    vecs[5] = '{1'b0, 32'h0, 32'h0, 1'b1, 64, 1'b0, 32'h0000AAAA, 32'h00005555, 3'b100, 32'h0000AAAA, 32'h00005555};
    vecs[6] = '{1'b0, 32'h0, 32'h0, 1'b0, 1, 1'b0, 32'h00000000, 32'h00000007, 3'b100, 32'h00000000, 32'h00000007};
    repeat (2) tick();
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_outs", {bus.busy, bus.mult_start, bus.div_start, bus.done, bus.div0_exc, bus.timeout_err}, 6'b0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) run_op(vecs[i]);
    bus.hi_write = 1'b1;
    bus.wdata = 32'hCAFE0000;
    tick();
    bus.hi_write = 1'b0;
    check("mthi_idle", bus.hi, 32'hCAFE0000);
    check("lo_kept", bus.lo, 32'h00000007);
    bus.op_sel = 1'b0;
    bus.op_start = 1'b1;
    tick();
    bus.op_start = 1'b0;
    tick();
    bus.mult_end = 1'b0;
    bus.hi_write = 1'b1;
    bus.lo_write = 1'b1;
    bus.wdata = 32'h12345678;
    tick();
    bus.hi_write = 1'b0;
    bus.lo_write = 1'b0;
    check("mthi_wait_ignored", bus.hi, 32'hCAFE0000);
    check("mtlo_wait_ignored", bus.lo, 32'h00000007);
    check("busy_mid", bus.busy, 1'b1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_hi", bus.hi, 32'h0);
    check("rst_mid_lo", bus.lo, 32'h0);
    bus.mult_end = 1'b1;
    bus.mult_high = 32'h55555555;
    bus.mult_low = 32'h66666666;
    repeat (4) begin
      tick();
      check("post_rst_flags", flags(), 3'b000);
      check("post_rst_busy", bus.busy, 1'b0);
      check("post_rst_hi", bus.hi, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
